// File: rtl/fpu_in2_gt_in1_iter_if.sv
// Handshake and operand/result bundle for the iterative magnitude comparator.
// The master drives operands and result acceptance; the slave (comparator) answers.
interface fpu_in2_gt_in1_iter_if #(
    parameter int WIDTH = 64
);
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic             sgn_mode;
    logic             out_vld;
    logic             out_rdy;
    logic             din2_neq_din1;
    logic             din2_gt_din1;

    modport master (
        output in_vld, din1, din2, sgn_mode, out_rdy,
        input  in_rdy, out_vld, din2_neq_din1, din2_gt_din1
    );

    modport slave (
        input  in_vld, din1, din2, sgn_mode, out_rdy,
        output in_rdy, out_vld, din2_neq_din1, din2_gt_din1
    );
endinterface

// File: rtl/fpu_in2_gt_in1_iter.sv
// Iterative din2-vs-din1 comparator: walks CHUNK-bit slices from the MSB end,
// stopping at the first differing slice, with a valid/ready result handshake.
module fpu_in2_gt_in1_iter #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 4
) (
    input logic                   rclk,
    input logic                   reset,
    fpu_in2_gt_in1_iter_if.slave  bus
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            in_rdy_q;
    logic            out_vld_q;
    logic            neq_q;
    logic            gt_q;
    logic [PW-1:0]   a_q, b_q;
    logic [PW-1:0]   a_d, b_d;
    logic [CHUNK-1:0] s1, s2;

    // Flipping the top bit after extension maps two's-complement order onto
    // unsigned order, so every slice can then be compared as unsigned.
    function automatic logic [PW-1:0] pad_op(input logic [WIDTH-1:0] v, input logic sgn);
        logic [PW-1:0] r;
        r            = {PW{sgn & v[WIDTH-1]}};
        r[WIDTH-1:0] = v;
        r[PW-1]      = r[PW-1] ^ sgn;
        return r;
    endfunction

    always_comb begin
        a_d = pad_op(bus.din1, bus.sgn_mode);
        b_d = pad_op(bus.din2, bus.sgn_mode);
        s1  = a_q[PW-1 -: CHUNK];
        s2  = b_q[PW-1 -: CHUNK];
    end

    // Operands shift left on each equal slice so the slice under test is always the top one.
    always_ff @(posedge rclk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            neq_q     <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_vld) begin
                        a_q      <= a_d;
                        b_q      <= b_d;
                        idx_q    <= IW'(NCHUNK - 1);
                        in_rdy_q <= 1'b0;
                        state_q  <= CMP;
                    end
                end
                CMP: begin
                    if (s1 != s2) begin
                        neq_q     <= 1'b1;
                        gt_q      <= (s2 > s1);
                        out_vld_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (idx_q != '0) begin
                        idx_q <= idx_q - 1'b1;
                        a_q   <= a_q << CHUNK;
                        b_q   <= b_q << CHUNK;
                    end else begin
                        neq_q     <= 1'b0;
                        gt_q      <= 1'b0;
                        out_vld_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_rdy) begin
                        out_vld_q <= 1'b0;
                        neq_q     <= 1'b0;
                        gt_q      <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    in_rdy_q  <= 1'b1;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_rdy        = in_rdy_q;
    assign bus.out_vld       = out_vld_q;
    assign bus.din2_neq_din1 = neq_q;
    assign bus.din2_gt_din1  = gt_q;
endmodule

// File: tb/tb_fpu_in2_gt_in1_iter.sv
// Scoreboard bench for the iterative comparator: a 64/4 instance and a 10/4
// instance, directed vectors with hand-computed results and chunk counts.
module tb_fpu_in2_gt_in1_iter;
    logic rclk = 1'b0;
    logic reset = 1'b1;
    int   errs = 0;
    int   nchk = 0;

    always #5 rclk = ~rclk;

    fpu_in2_gt_in1_iter_if #(.WIDTH(64)) b64 ();
    fpu_in2_gt_in1_iter_if #(.WIDTH(10)) b10 ();

    fpu_in2_gt_in1_iter #(.WIDTH(64), .CHUNK(4)) u64 (.rclk(rclk), .reset(reset), .bus(b64));
    fpu_in2_gt_in1_iter #(.WIDTH(10), .CHUNK(4)) u10 (.rclk(rclk), .reset(reset), .bus(b10));

    typedef struct {
        logic neq;
        logic gt;
        int   m;
        time  t;
    } exp_t;

    exp_t q64[$];
    exp_t q10[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: pop on each rising out_vld, then require stable results while held.
    initial begin : mon64
        logic prev, hn, hg;
        exp_t e;
        prev = 1'b0; hn = 1'b0; hg = 1'b0;
        forever begin
            @(negedge rclk);
            if (reset) begin
                prev = 1'b0;
            end else if (b64.out_vld && !prev) begin
                if (q64.size() == 0) begin
                    chk("w64_spurious_result", 1, 0);
                end else begin
                    e = q64.pop_front();
                    chk("w64_neq", b64.din2_neq_din1, e.neq);
                    chk("w64_gt", b64.din2_gt_din1, e.gt);
                    chk("w64_latency", int'(($time - e.t - 5) / 10), e.m);
                end
                hn = b64.din2_neq_din1; hg = b64.din2_gt_din1;
                prev = 1'b1;
            end else if (b64.out_vld) begin
                chk("w64_hold_neq", b64.din2_neq_din1, hn);
                chk("w64_hold_gt", b64.din2_gt_din1, hg);
            end else begin
                prev = 1'b0;
            end
        end
    end

    initial begin : mon10
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge rclk);
            if (reset) begin
                prev = 1'b0;
            end else if (b10.out_vld && !prev) begin
                if (q10.size() == 0) begin
                    chk("w10_spurious_result", 1, 0);
                end else begin
                    e = q10.pop_front();
                    chk("w10_neq", b10.din2_neq_din1, e.neq);
                    chk("w10_gt", b10.din2_gt_din1, e.gt);
                    chk("w10_latency", int'(($time - e.t - 5) / 10), e.m);
                end
                prev = 1'b1;
            end else begin
                prev = b10.out_vld;
            end
        end
    end

    task automatic issue(input bit w10, input logic [63:0] a, input logic [63:0] b,
                         input bit s, input bit en, input bit eg, input int em);
        exp_t e;
        int   n;
        @(negedge rclk);
        if (w10) begin
            b10.din1 = a[9:0]; b10.din2 = b[9:0]; b10.sgn_mode = s; b10.in_vld = 1'b1;
        end else begin
            b64.din1 = a; b64.din2 = b; b64.sgn_mode = s; b64.in_vld = 1'b1;
        end
        n = 0;
        while (!(w10 ? b10.in_rdy : b64.in_rdy) && n < 100) begin
            @(negedge rclk);
            n++;
        end
        if (n >= 100) begin
            nchk++; errs++;
            $display("FAIL issue_timeout: in_rdy stayed 0 for %0d cycles, required 1", n);
        end else begin
            @(posedge rclk);
            e.neq = en; e.gt = eg; e.m = em; e.t = $time;
            if (w10) q10.push_back(e); else q64.push_back(e);
        end
        #1;
        b10.in_vld = 1'b0;
        b64.in_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q64.size() != 0 || q10.size() != 0 || b64.out_vld || b10.out_vld) && n < 300) begin
            @(negedge rclk);
            n++;
        end
        if (n >= 300) begin
            nchk++; errs++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", q64.size() + q10.size());
        end
    endtask

    initial begin
        b64.in_vld = 1'b0; b64.din1 = '0; b64.din2 = '0; b64.sgn_mode = 1'b0; b64.out_rdy = 1'b1;
        b10.in_vld = 1'b0; b10.din1 = '0; b10.din2 = '0; b10.sgn_mode = 1'b0; b10.out_rdy = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge rclk);
        chk("rst_in_rdy", b64.in_rdy, 1);
        chk("rst_out_vld", b64.out_vld, 0);
        chk("rst_neq", b64.din2_neq_din1, 0);
        chk("rst_gt", b64.din2_gt_din1, 0);
        chk("rst10_in_rdy", b10.in_rdy, 1);
        reset = 1'b0;

        // 64-bit vectors: a, b, signed, neq, gt, chunks examined
        issue(0, 64'h0, 64'h8000_0000_0000_0000, 0, 1, 1, 1);
        issue(0, 64'h10, 64'h11, 0, 1, 1, 16);
        issue(0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 16);
        issue(0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1, 1);
        issue(0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 1);
        issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1, 0, 16);
        issue(0, 64'hFFFF_FFFF_FFFF_FFFB, 64'h3, 1, 1, 1, 1);
        issue(0, 64'h0000_0100_0000_0000, 64'h0000_0200_0000_0000, 0, 1, 1, 6);
        issue(0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1, 0, 0, 16);

        // 10-bit instance: operands padded to 12 bits
        issue(1, 64'h200, 64'h1FF, 1, 1, 1, 1);
        issue(1, 64'h3FF, 64'h3FE, 0, 1, 0, 3);
        issue(1, 64'h3FF, 64'h000, 1, 1, 1, 1);
        issue(1, 64'h155, 64'h155, 1, 0, 0, 3);
        drain();

        // Backpressure: result held while in_vld is asserted with other operands
        b64.out_rdy = 1'b0;
        issue(0, 64'h5, 64'h3, 0, 1, 0, 16);
        begin
            int n;
            n = 0;
            while (!b64.out_vld && n < 50) begin
                @(negedge rclk);
                n++;
            end
            chk("bp_out_vld_rise", b64.out_vld, 1);
        end
        b64.din1 = 64'h0; b64.din2 = 64'hFFFF_0000_0000_0000; b64.in_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge rclk);
            chk("bp_in_rdy", b64.in_rdy, 0);
            chk("bp_out_vld", b64.out_vld, 1);
        end
        b64.out_rdy = 1'b1;
        b64.in_vld = 1'b0;
        @(negedge rclk);
        chk("bp_release_out_vld", b64.out_vld, 0);
        chk("bp_release_in_rdy", b64.in_rdy, 1);
        repeat (20) @(negedge rclk);
        drain();

        // Reset during the third CMP cycle of a 16-chunk operation
        issue(0, 64'hAAAA_5555_AAAA_5555, 64'hAAAA_5555_AAAA_5555, 0, 0, 0, 16);
        repeat (2) @(negedge rclk);
        @(negedge rclk);
        reset = 1'b1;
        q64.delete();
        @(negedge rclk);
        reset = 1'b0;
        chk("midrst_in_rdy", b64.in_rdy, 1);
        chk("midrst_out_vld", b64.out_vld, 0);
        chk("midrst_neq", b64.din2_neq_din1, 0);
        chk("midrst_gt", b64.din2_gt_din1, 0);
        issue(0, 64'h0000_0100_0000_0000, 64'h0000_0200_0000_0000, 0, 1, 1, 6);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule

// File: doc/fpu_in2_gt_in1_iter.md
FPU_IN2_GT_IN1_ITER -- requirements
Module: fpu_in2_gt_in1_iter

Interface
REQ-001 Parameter WIDTH, default 64: operand width in bits, legal range >= 1.
REQ-002 Parameter CHUNK, default 4: bits compared per cycle, legal range 1..WIDTH; NCHUNK = ceil(WIDTH/CHUNK), PW = NCHUNK*CHUNK.
REQ-003 rclk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_vld  input  1  operands and mode valid.
REQ-006 in_rdy  output  1  block can accept operands.
REQ-007 din1  input  WIDTH  operand 1.
REQ-008 din2  input  WIDTH  operand 2.
REQ-009 sgn_mode  input  1  1 = two's-complement signed compare, 0 = unsigned.
REQ-010 out_vld  output  1  result valid.
REQ-011 out_rdy  input  1  consumer accepts result.
REQ-012 din2_neq_din1  output  1  din2 != din1.
REQ-013 din2_gt_din1  output  1  din2 > din1 under the captured mode.

Function
REQ-014 FSM states SHALL be IDLE, CMP, DONE; in_rdy = (state == IDLE); out_vld = (state == DONE), registered.
REQ-015 The block SHALL accept on an edge with in_vld && in_rdy, capturing padded operands and moving IDLE->CMP with chunk index = NCHUNK-1; in_vld SHALL be ignored outside IDLE.
REQ-016 Capture padding SHALL extend each operand to PW bits: sign-extend if sgn_mode=1, zero-extend if 0, then XOR bit PW-1 with sgn_mode.
REQ-017 Each CMP cycle SHALL compare the CHUNK-bit slice at the current index of both padded operands as unsigned values, MSB chunk first.
REQ-018 On slice inequality: latch neq=1, gt=(slice2 > slice1), go to DONE.
REQ-019 On slice equality with index > 0: decrement index, stay in CMP.
REQ-020 On slice equality with index == 0: latch neq=0, gt=0, go to DONE.
REQ-021 Latency: with m = number of chunks examined (1..NCHUNK), out_vld SHALL rise exactly m rising edges after the accepting edge.
REQ-022 In DONE, din2_neq_din1/din2_gt_din1 SHALL hold stable until out_rdy=1; that edge SHALL return to IDLE with out_vld=0.
REQ-023 Results are meaningful only while out_vld=1; outside DONE both result outputs SHALL be 0.
REQ-024 A new operand SHALL NOT be accepted on the same edge a result is consumed; at most one operation is in flight.
REQ-025 Behaviour SHALL be identical to a full-width combinational compare of the mode-interpreted operands for every input, including WIDTH not a multiple of CHUNK.

Reset
REQ-026 reset=1 on any edge SHALL force IDLE, chunk index 0, out_vld=0, din2_neq_din1=0, din2_gt_din1=0, in_rdy=1 after that edge, discarding any operation in progress.
REQ-027 reset SHALL take priority over in_vld and out_rdy on the same edge.

Verification (WIDTH=64, CHUNK=4 unless stated; out_rdy=1 unless stated)
REQ-028 Unsigned din1=0, din2=0x8000_0000_0000_0000 -> m=1, out_vld 1 edge after accept, neq=1, gt=1.
REQ-029 Unsigned din1=0x10, din2=0x11 -> m=16, out_vld 16 edges after accept, neq=1, gt=1; din1=din2=0x0123_4567_89AB_CDEF -> m=16, neq=0, gt=0.
REQ-030 din1=1, din2=0xFFFF_FFFF_FFFF_FFFF: sgn_mode=0 -> gt=1, neq=1; sgn_mode=1 -> gt=0, neq=1; both m=1.
REQ-031 WIDTH=10, CHUNK=4, sgn_mode=1, din1=10'h200, din2=10'h1FF -> m=1, neq=1, gt=1.
REQ-032 Backpressure: hold out_rdy=0 for 5 cycles in DONE with in_vld=1 -> out_vld and results stable, in_rdy=0, no capture; out_rdy=1 -> IDLE next edge.
REQ-033 Reset asserted during the 3rd CMP cycle of an m=16 operation -> next edge in_rdy=1, out_vld=0, results 0; a following op completes correctly.
